// File: rtl/vsq_dequant_unit.sv
// rtl/vsq_dequant_unit.sv - VSQ vector dequantizer: input FIFO, restoring reciprocal divider, 16-lane scale multiply
module vsq_dequant_unit #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic [135:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [287:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_zero_scale,
  output logic         busy,
  output logic [15:0]  vec_count
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [20:0]    DIVIDEND = 21'h100000;

  typedef enum logic [1:0] {IDLE, DIV, MUL, OUT} state_t;

  state_t state, state_nx;

  logic [135:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             full, empty, push, pop;
  logic [135:0]     head;

  logic [127:0] codes;
  logic [7:0]   scale;
  logic         zflag;
  logic [7:0]   rem;
  logic [20:0]  dvd;
  logic [4:0]   div_cnt;
  logic [8:0]   trial, diff;
  logic         trial_ge;
  logic [20:0]  inv;
  logic [287:0] mul_data;
  logic         handshake;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign in_ready  = !full;
  assign push      = in_valid && !full;
  assign head      = mem[rd_ptr];
  assign busy      = (state != IDLE) || !empty;
  assign handshake = (state == OUT) && out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     state <= IDLE;
    else if (flush) state <= IDLE;
    else            state <= state_nx;
  end

  // OUT pops the next vector in the handshake cycle so back-to-back vectors skip IDLE
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          state_nx = DIV;
        end
      end
      DIV: begin
        if (div_cnt == 5'd20) state_nx = MUL;
      end
      MUL: state_nx = OUT;
      OUT: begin
        if (handshake) begin
          if (!empty) begin
            pop      = 1'b1;
            state_nx = DIV;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Partial remainder stays below the 8-bit scale, so one extra bit holds the shifted trial
  assign trial    = {rem, dvd[20]};
  assign trial_ge = (trial >= {1'b0, scale});
  assign diff     = trial - {1'b0, scale};
  assign inv      = zflag ? 21'd0 : dvd;

  for (genvar g = 0; g < 16; g++) begin : g_lane
    logic [28:0] prod;
    assign prod = 29'(codes[g*8 +: 8]) * 29'(inv);
    assign mul_data[g*18 +: 18] = {5'b0, prod[28:16]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      codes          <= '0;
      scale          <= '0;
      zflag          <= 1'b0;
      rem            <= '0;
      dvd            <= '0;
      div_cnt        <= '0;
      out_data       <= '0;
      out_valid      <= 1'b0;
      out_zero_scale <= 1'b0;
      vec_count      <= '0;
    end else if (flush) begin
      codes          <= '0;
      scale          <= '0;
      zflag          <= 1'b0;
      rem            <= '0;
      dvd            <= '0;
      div_cnt        <= '0;
      out_data       <= '0;
      out_valid      <= 1'b0;
      out_zero_scale <= 1'b0;
      vec_count      <= '0;
    end else begin
      if (pop) begin
        codes   <= head[127:0];
        scale   <= head[135:128];
        zflag   <= (head[135:128] == 8'd0);
        rem     <= '0;
        dvd     <= DIVIDEND;
        div_cnt <= '0;
      end else if (state == DIV) begin
        rem     <= trial_ge ? diff[7:0] : trial[7:0];
        dvd     <= {dvd[19:0], trial_ge};
        div_cnt <= div_cnt + 1'b1;
      end
      if (state == MUL) begin
        out_data       <= mul_data;
        out_valid      <= 1'b1;
        out_zero_scale <= zflag;
      end
      if (handshake) begin
        out_valid <= 1'b0;
        vec_count <= vec_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vsq_dequant_unit.sv
// tb/tb_vsq_dequant_unit.sv - self-checking bench for vsq_dequant_unit against an arithmetic reference model
module tb_vsq_dequant_unit;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic [135:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [287:0] out_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         out_zero_scale;
  logic         busy;
  logic [15:0]  vec_count;

  int checks = 0;
  int failures = 0;
  logic [135:0] exp_q[$];

  vsq_dequant_unit #(.DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_zero_scale(out_zero_scale), .busy(busy), .vec_count(vec_count)
  );

  always #5 clk = ~clk;

  function automatic logic [287:0] model(input logic [135:0] v);
    logic [287:0] r;
    longint unsigned s, inv, q, p;
    r = '0;
    s = 64'(v[135:128]);
    inv = (s == 0) ? 64'd0 : (64'd1048576 / s);
    for (int i = 0; i < 16; i++) begin
      q = 64'(v[i*8 +: 8]);
      p = (q * inv) >> 16;
      r[i*18 +: 18] = 18'(p);
    end
    return r;
  endfunction

  function automatic logic [135:0] fill_vec(input logic [7:0] s, input logic [7:0] q);
    logic [135:0] v;
    for (int i = 0; i < 16; i++) v[i*8 +: 8] = q;
    v[135:128] = s;
    return v;
  endfunction

  function automatic logic [135:0] rand_vec(input logic [7:0] s);
    logic [135:0] v;
    for (int i = 0; i < 16; i++) v[i*8 +: 8] = 8'($urandom);
    v[135:128] = s;
    return v;
  endfunction

  function automatic logic [287:0] fill_out(input logic [17:0] lane);
    logic [287:0] r;
    for (int i = 0; i < 16; i++) r[i*18 +: 18] = lane;
    return r;
  endfunction

  task automatic push_vec(input logic [135:0] v, output bit ok);
    ok = 1'b0;
    in_data  = v;
    in_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      if (in_ready) begin
        @(negedge clk);
        ok = 1'b1;
        exp_q.push_back(v);
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int bound, output logic [287:0] d, output logic z,
                          output int cyc, output bit ok);
    ok = 1'b0;
    cyc = 0;
    d = '0;
    z = 1'b0;
    while (cyc < bound) begin
      if (out_valid) begin
        ok = 1'b1;
        d = out_data;
        z = out_zero_scale;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    if (ok && out_ready) @(negedge clk);
  endtask

  task automatic flush_dut();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_zero_scale !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs valid=%b zero=%b data_nonzero=%b", out_valid, out_zero_scale, |out_data);
    end
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || vec_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_status in_ready=%b busy=%b vec_count=%0d expected 1 0 0", in_ready, busy, vec_count);
    end
  endtask

  task automatic test_latency();
    logic [287:0] d;
    logic z;
    int cyc;
    bit ok;
    out_ready = 1'b1;
    push_vec(fill_vec(8'd16, 8'd200), ok);
    void'(exp_q.pop_front());
    wait_out(60, d, z, cyc, ok);
    checks++;
    if (!ok || cyc != 23) begin
      failures++;
      $display("FAIL latency_s16 got=%0d cycles (seen=%b) expected 23", cyc, ok);
    end
    checks++;
    if (d !== fill_out(18'd200) || z !== 1'b0) begin
      failures++;
      $display("FAIL data_s16 got=%h zero=%b expected lanes 200 zero 0", d, z);
    end
    checks++;
    if (vec_count !== 16'd1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL count_after_first vec_count=%0d valid=%b expected 1 0", vec_count, out_valid);
    end
  endtask

  task automatic test_accuracy();
    logic [287:0] d, e;
    logic z;
    int cyc;
    bit ok;
    logic [135:0] v;
    out_ready = 1'b1;
    push_vec(fill_vec(8'd1, 8'd255), ok);
    void'(exp_q.pop_front());
    wait_out(60, d, z, cyc, ok);
    checks++;
    if (!ok || d !== fill_out(18'd4080)) begin
      failures++;
      $display("FAIL acc_s1 got=%h expected lanes 4080", d);
    end
    push_vec(fill_vec(8'd255, 8'd255), ok);
    void'(exp_q.pop_front());
    wait_out(60, d, z, cyc, ok);
    checks++;
    if (!ok || d !== fill_out(18'd15)) begin
      failures++;
      $display("FAIL acc_s255 got=%h expected lanes 15", d);
    end
    v = fill_vec(8'd3, 8'd0);
    v[7:0] = 8'd1;
    push_vec(v, ok);
    void'(exp_q.pop_front());
    wait_out(60, d, z, cyc, ok);
    checks++;
    if (!ok || d[17:0] !== 18'd5 || d[35:18] !== 18'd0) begin
      failures++;
      $display("FAIL acc_s3 lane0=%0d lane1=%0d expected 5 0", d[17:0], d[35:18]);
    end
    for (int k = 0; k < 12; k++) begin
      v = rand_vec((k == 5) ? 8'd0 : 8'($urandom_range(1, 255)));
      push_vec(v, ok);
      e = model(exp_q.pop_front());
      wait_out(60, d, z, cyc, ok);
      checks++;
      if (!ok || d !== e || z !== (v[135:128] == 8'd0)) begin
        failures++;
        $display("FAIL acc_rand%0d s=%0d got=%h expected=%h", k, v[135:128], d, e);
      end
    end
  endtask

  task automatic test_zero_scale();
    logic [287:0] d;
    logic z;
    int cyc;
    bit ok;
    out_ready = 1'b1;
    push_vec(fill_vec(8'd0, 8'd100), ok);
    void'(exp_q.pop_front());
    wait_out(60, d, z, cyc, ok);
    checks++;
    if (!ok || cyc != 23) begin
      failures++;
      $display("FAIL zero_latency got=%0d expected 23", cyc);
    end
    checks++;
    if (d !== '0 || z !== 1'b1) begin
      failures++;
      $display("FAIL zero_data got=%h zero=%b expected 0 1", d, z);
    end
  endtask

  task automatic test_backpressure();
    logic [287:0] d, d0, e;
    logic z;
    int cyc;
    bit ok, all_ok, stable;
    flush_dut();
    out_ready = 1'b0;
    all_ok = 1'b1;
    for (int k = 0; k < 5; k++) begin
      push_vec(rand_vec(8'($urandom_range(1, 255))), ok);
      all_ok &= ok;
    end
    checks++;
    if (!all_ok || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_full accepted_all=%b in_ready=%b expected 1 0", all_ok, in_ready);
    end
    wait_out(60, d0, z, cyc, ok);
    stable = ok;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (out_data !== d0 || out_valid !== 1'b1) stable = 1'b0;
    end
    checks++;
    if (!stable) begin
      failures++;
      $display("FAIL bp_stable valid=%b data_held=%b expected 1 1", out_valid, out_data === d0);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      e = model(exp_q.pop_front());
      wait_out(60, d, z, cyc, ok);
      checks++;
      if (!ok || d !== e || cyc != ((k == 0) ? 0 : 22)) begin
        failures++;
        $display("FAIL bp_drain%0d cyc=%0d got=%h expected=%h", k, cyc, d, e);
      end
    end
    checks++;
    if (vec_count !== 16'd5) begin
      failures++;
      $display("FAIL bp_count got=%0d expected 5", vec_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [287:0] d, e;
    logic [135:0] v;
    int cyc, next;
    bit ok;
    flush_dut();
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      v = rand_vec(8'd16);
      v[7:0] = 8'(k);
      push_vec(v, ok);
    end
    next = 2;
    for (int k = 0; k < 8; k++) begin
      cyc = 0;
      while (!out_valid && cyc < 60) begin
        @(negedge clk);
        cyc++;
      end
      e = model(exp_q.pop_front());
      d = out_data;
      checks++;
      if (!out_valid || d !== e || d[17:0] !== 18'(k) || (k > 0 && cyc != 22)) begin
        failures++;
        $display("FAIL b2b%0d cyc=%0d seq=%0d got=%h expected=%h", k, cyc, d[17:0], d, e);
      end
      if (next < 8) begin
        v = rand_vec(8'd16);
        v[7:0] = 8'(next);
        in_data = v;
        in_valid = 1'b1;
        exp_q.push_back(v);
        next++;
      end
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL b2b_ready%0d in_ready=%b expected 1", k, in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (vec_count !== 16'd8 || busy !== 1'b0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL b2b_end vec_count=%0d busy=%b left=%0d expected 8 0 0", vec_count, busy, exp_q.size());
    end
  endtask

  task automatic post_clear_check(input string tag);
    logic [287:0] d, e;
    logic z;
    int cyc;
    bit ok, stray;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || vec_count !== 16'd0) begin
      failures++;
      $display("FAIL %s_clear valid=%b busy=%b in_ready=%b vec_count=%0d expected 0 0 1 0",
               tag, out_valid, busy, in_ready, vec_count);
    end
    out_ready = 1'b1;
    push_vec(rand_vec(8'($urandom_range(1, 255))), ok);
    e = model(exp_q.pop_front());
    wait_out(60, d, z, cyc, ok);
    checks++;
    if (!ok || cyc != 23 || d !== e || vec_count !== 16'd1) begin
      failures++;
      $display("FAIL %s_next cyc=%0d count=%0d got=%h expected=%h", tag, cyc, vec_count, d, e);
    end
    stray = 1'b0;
    for (int t = 0; t < 40; t++) begin
      if (out_valid || busy) stray = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (stray) begin
      failures++;
      $display("FAIL %s_stale stray output or busy after clear=%b expected 0", tag, stray);
    end
  endtask

  task automatic test_flush();
    logic [287:0] d;
    logic z;
    int cyc;
    bit ok;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) push_vec(rand_vec(8'd7), ok);
    repeat (5) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    exp_q.delete();
    post_clear_check("flush");
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) push_vec(rand_vec(8'd9), ok);
    wait_out(60, d, z, cyc, ok);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_data !== '0 || out_zero_scale !== 1'b0) begin
      failures++;
      $display("FAIL rst_async data_nonzero=%b zero=%b expected 0 0", |out_data, out_zero_scale);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    post_clear_check("rst");
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_latency();
    test_accuracy();
    test_zero_scale();
    test_backpressure();
    test_back_to_back();
    test_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
